// File: rtl/instruction_loader.sv
// Boot-time program loader: unpacks a length-prefixed byte stream into 32-bit
// little-endian instruction words and holds the core in reset until loading ends.
module instruction_loader #(
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  inValid,
   input  logic [7:0]            inData,
   output logic                  inReady,
   output logic                  memWrite,
   output logic [ADDR_WIDTH-1:0] memAddress,
   output logic [31:0]           memWriteData,
   output logic                  coreReset,
   output logic                  done,
   output logic                  error,
   output logic [ADDR_WIDTH:0]   wordsLoaded
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   typedef enum logic [2:0] {
      LEN_LO,
      LEN_HI,
      DATA,
      DONE,
      ERROR
   } state_t;

   state_t                state;
   logic [7:0]            len_lo;
   logic [ADDR_WIDTH:0]   len_q;
   logic [ADDR_WIDTH:0]   word_idx;
   logic [1:0]            byte_idx;
   logic [23:0]           partial;

   logic                  xfer;
   logic [15:0]           full_len;
   logic [ADDR_WIDTH:0]   next_word;

   // NOTE: every signal assigned here gets a default first, so no latch is inferred.
   always_comb begin
      inReady = 1'b0;
      if (!reset) begin
         case (state)
            LEN_LO, LEN_HI, DATA: inReady = 1'b1;
            default:              inReady = 1'b0;
         endcase
      end
      xfer      = inValid && inReady;
      full_len  = {inData, len_lo};
      next_word = word_idx + (ADDR_WIDTH+1)'(1);
   end

   // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= LEN_LO;
         len_lo       <= '0;
         len_q        <= '0;
         word_idx     <= '0;
         byte_idx     <= '0;
         partial      <= '0;
         memWrite     <= 1'b0;
         memAddress   <= '0;
         memWriteData <= '0;
         coreReset    <= 1'b1;
         done         <= 1'b0;
         error        <= 1'b0;
         wordsLoaded  <= '0;
      end else begin
         memWrite <= 1'b0;
         case (state)
            LEN_LO: begin
               if (xfer) begin
                  len_lo <= inData;
                  state  <= LEN_HI;
               end
            end
            LEN_HI: begin
               if (xfer) begin
                  len_q <= full_len[ADDR_WIDTH:0];
                  if (full_len == 16'd0) begin
                     state     <= DONE;
                     done      <= 1'b1;
                     coreReset <= 1'b0;
                  end else if ({16'd0, full_len} > 32'(DEPTH)) begin
                     state <= ERROR;
                     error <= 1'b1;
                  end else begin
                     state    <= DATA;
                     word_idx <= '0;
                     byte_idx <= '0;
                  end
               end
            end
            DATA: begin
               if (xfer) begin
                  byte_idx <= byte_idx + 2'd1;
                  case (byte_idx)
                     2'd0: partial[7:0]   <= inData;
                     2'd1: partial[15:8]  <= inData;
                     2'd2: partial[23:16] <= inData;
                     default: begin
                        memWrite     <= 1'b1;
                        memWriteData <= {inData, partial};
                        memAddress   <= word_idx[ADDR_WIDTH-1:0];
                        wordsLoaded  <= next_word;
                        word_idx     <= next_word;
                        // The word counter stops at len_q, so it never wraps past DEPTH-1.
                        if (next_word == len_q) begin
                           state     <= DONE;
                           done      <= 1'b1;
                           coreReset <= 1'b0;
                        end
                     end
                  endcase
               end
            end
            default: ;
         endcase
      end
   end

endmodule
